// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared by the VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned CLK_DIV_DEF     = 4;
  localparam int unsigned H_TOTAL_DEF     = 800;
  localparam int unsigned H_SYNC_DEF      = 96;
  localparam int unsigned H_ACT_START_DEF = 144;
  localparam int unsigned H_ACT_END_DEF   = 784;
  localparam int unsigned V_TOTAL_DEF     = 525;
  localparam int unsigned V_SYNC_DEF      = 2;
  localparam int unsigned V_ACT_START_DEF = 35;
  localparam int unsigned V_ACT_END_DEF   = 515;

  localparam int unsigned CntW = 10;

  typedef logic [CntW-1:0] cnt_t;

  // Half-open window test: lo <= c < hi.
  function automatic logic in_win(cnt_t c, cnt_t lo, cnt_t hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/pix_clk_en.sv
// Pixel strobe divider: one-clk pix_en every CLK_DIV system clocks.
module pix_clk_en
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int unsigned   DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] r_div;

  // Free-running 0..CLK_DIV-1 counter, cleared by synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div <= '0;
    end else if (r_div == DivLast) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DivW'(1);
    end
  end

  // With CLK_DIV==1 DivLast is 0, so the strobe is permanently high.
  assign pix_en = (r_div == DivLast);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, syncs, visible window and frame markers.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
  parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_ACT_START = H_ACT_START_DEF,
  parameter int unsigned H_ACT_END   = H_ACT_END_DEF,
  parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_ACT_START = V_ACT_START_DEF,
  parameter int unsigned V_ACT_END   = V_ACT_END_DEF
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam cnt_t HLast     = cnt_t'(H_TOTAL - 1);
  localparam cnt_t VLast     = cnt_t'(V_TOTAL - 1);
  localparam cnt_t HSyncEnd  = cnt_t'(H_SYNC);
  localparam cnt_t VSyncEnd  = cnt_t'(V_SYNC);
  localparam cnt_t HActStart = cnt_t'(H_ACT_START);
  localparam cnt_t HActEnd   = cnt_t'(H_ACT_END);
  localparam cnt_t VActStart = cnt_t'(V_ACT_START);
  localparam cnt_t VActEnd   = cnt_t'(V_ACT_END);

  logic w_pix_en;
  logic w_h_last;
  logic w_v_last;
  cnt_t r_h;
  cnt_t r_v;
  logic [7:0] r_frame_cnt;
  // The (0,0) strobe straight after reset and the one after 256 frames look identical
  // in the counters, so this flag marks that at least one frame has wrapped.
  logic r_frame_seen;

  pix_clk_en #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_clk_en (
    .clk   (clk),
    .rst   (rst),
    .pix_en(w_pix_en)
  );

  assign w_h_last = (r_h == HLast);
  assign w_v_last = (r_v == VLast);

  // Raster counters advance on the pixel strobe; reset overrides any increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_h          <= '0;
      r_v          <= '0;
      r_frame_cnt  <= '0;
      r_frame_seen <= 1'b0;
    end else if (w_pix_en) begin
      if (w_h_last) begin
        r_h <= '0;
        if (w_v_last) begin
          r_v          <= '0;
          r_frame_cnt  <= r_frame_cnt + 8'd1;
          r_frame_seen <= 1'b1;
        end else begin
          r_v <= r_v + cnt_t'(1);
        end
      end else begin
        r_h <= r_h + cnt_t'(1);
      end
    end
  end

  // Zero-latency decode of the registered counters.
  always_comb begin
    pix_en      = w_pix_en;
    hCount      = r_h;
    vCount      = r_v;
    frame_cnt   = r_frame_cnt;
    hSync       = (r_h >= HSyncEnd);
    vSync       = (r_v >= VSyncEnd);
    bright      = in_win(r_h, HActStart, HActEnd) && in_win(r_v, VActStart, VActEnd);
    frame_start = w_pix_en && (r_h == '0) && (r_v == '0) && r_frame_seen;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default build (A), CLK_DIV=1 full raster (B), CLK_DIV=1 tiny raster (S).
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pe;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       br;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  // Tiny raster for instance S so whole frames fit in a short run.
  localparam int unsigned SD = 1, SHT = 8, SHS = 2, SHA = 3, SHE = 7;
  localparam int unsigned SVT = 4, SVS = 1, SVA = 1, SVE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_s;
  logic a_pe, a_hs, a_vs, a_br, a_fs, b_pe, b_hs, b_vs, b_br, b_fs, s_pe, s_hs, s_vs, s_br, s_fs;
  logic [9:0] a_h, a_v, b_h, b_v, s_h, s_v;
  logic [7:0] a_fc, b_fc, s_fc;
  obs_t a_obs, s_obs, exp_o;

  int unsigned k_a = 0, k_b = 0, k_s = 0;
  int n_vec = 0;
  int n_err = 0;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .pix_en(a_pe), .hCount(a_h), .vCount(a_v), .hSync(a_hs),
    .vSync(a_vs), .bright(a_br), .frame_start(a_fs), .frame_cnt(a_fc)
  );

  vga_timing_gen #(.CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst_b), .pix_en(b_pe), .hCount(b_h), .vCount(b_v), .hSync(b_hs),
    .vSync(b_vs), .bright(b_br), .frame_start(b_fs), .frame_cnt(b_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(SD), .H_TOTAL(SHT), .H_SYNC(SHS), .H_ACT_START(SHA), .H_ACT_END(SHE),
    .V_TOTAL(SVT), .V_SYNC(SVS), .V_ACT_START(SVA), .V_ACT_END(SVE)
  ) dut_s (
    .clk(clk), .rst(rst_s), .pix_en(s_pe), .hCount(s_h), .vCount(s_v), .hSync(s_hs),
    .vSync(s_vs), .bright(s_br), .frame_start(s_fs), .frame_cnt(s_fc)
  );

  assign a_obs = {a_pe, a_h, a_v, a_hs, a_vs, a_br, a_fs, a_fc};
  assign s_obs = {s_pe, s_h, s_v, s_hs, s_vs, s_br, s_fs, s_fc};

  // Reference: k = clk edges since the last reset edge; everything follows from k.
  always @(posedge clk) begin
    k_a <= rst_a ? k_a + 1 : 0;
    k_b <= rst_b ? k_b + 1 : 0;
    k_s <= rst_s ? k_s + 1 : 0;
  end

  function automatic obs_t model(int unsigned k, int unsigned d, int unsigned ht,
                                 int unsigned hsy, int unsigned has, int unsigned hae,
                                 int unsigned vt, int unsigned vsy, int unsigned vas,
                                 int unsigned vae);
    obs_t o;
    int unsigned p  = k / d;
    int unsigned hh = p % ht;
    int unsigned vv = (p / ht) % vt;
    o.pe = ((k % d) == d - 1);
    o.h  = 10'(hh);
    o.v  = 10'(vv);
    o.hs = !(hh < hsy);
    o.vs = !(vv < vsy);
    o.br = (hh >= has) && (hh < hae) && (vv >= vas) && (vv < vae);
    o.fs = o.pe && (p % (ht * vt) == 0) && (p > 0);
    o.fc = 8'((p / (ht * vt)) % 256);
    return o;
  endfunction

  function automatic obs_t model_a(int unsigned k);
    return model(k, 4, 800, 96, 144, 784, 525, 2, 35, 515);
  endfunction

  function automatic obs_t model_s(int unsigned k);
    return model(k, SD, SHT, SHS, SHA, SHE, SVT, SVS, SVA, SVE);
  endfunction

  // Bounded wait for a raster position on instance 0=A, 1=B, 2=S (tv<0: any line).
  task automatic wait_pos(input int which, input int th, input int tv, input bit need_pe,
                          input int limit, output bit ok);
    logic [9:0] h, v;
    logic pe;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      case (which)
        0:       begin h = a_h; v = a_v; pe = a_pe; end
        1:       begin h = b_h; v = b_v; pe = b_pe; end
        default: begin h = s_h; v = s_v; pe = s_pe; end
      endcase
      if (h == 10'(th) && (tv < 0 || v == 10'(tv)) && (pe || !need_pe)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    obs_t exp_a_rst, exp_s_rst;
    exp_a_rst = '0;
    exp_s_rst = '0;
    exp_s_rst.pe = 1'b1;
    rst_a = 1'b0; rst_b = 1'b0; rst_s = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (a_obs !== exp_a_rst) begin
      n_err++;
      $display("FAIL reset_a: got %h want %h", a_obs, exp_a_rst);
    end
    n_vec++;
    if (s_obs !== exp_s_rst) begin
      n_err++;
      $display("FAIL reset_s_div1: got %h want %h", s_obs, exp_s_rst);
    end
    rst_a = 1'b1; rst_b = 1'b1; rst_s = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      n_vec++;
      if (a_pe !== (c == 4)) begin
        n_err++;
        $display("FAIL first_pix_en cycle %0d: got %b want %b", c, a_pe, (c == 4));
      end
    end
    @(negedge clk);
    n_vec++;
    if (a_h !== 10'd1 || a_v !== 10'd0) begin
      n_err++;
      $display("FAIL first_pixel_count: got h=%0d v=%0d want h=1 v=0", a_h, a_v);
    end
  endtask

  task automatic test_sync();
    bit ok;
    wait_pos(0, 95, 0, 1'b0, 2000, ok);
    n_vec++;
    if (!ok || a_hs !== 1'b0 || a_br !== 1'b0) begin
      n_err++;
      $display("FAIL hsync_at_95: got ok=%b hs=%b br=%b want ok=1 hs=0 br=0", ok, a_hs, a_br);
    end
    wait_pos(0, 96, 0, 1'b0, 100, ok);
    n_vec++;
    if (!ok || a_hs !== 1'b1) begin
      n_err++;
      $display("FAIL hsync_at_96: got ok=%b hs=%b want ok=1 hs=1", ok, a_hs);
    end
    wait_pos(1, 0, 1, 1'b0, 5000, ok);
    n_vec++;
    if (!ok || b_vs !== 1'b0) begin
      n_err++;
      $display("FAIL vsync_at_v1: got ok=%b vs=%b want ok=1 vs=0", ok, b_vs);
    end
    wait_pos(1, 0, 2, 1'b0, 5000, ok);
    n_vec++;
    if (!ok || b_vs !== 1'b1) begin
      n_err++;
      $display("FAIL vsync_at_v2: got ok=%b vs=%b want ok=1 vs=1", ok, b_vs);
    end
  endtask

  task automatic test_line_wrap();
    bit ok;
    wait_pos(0, 799, 0, 1'b1, 5000, ok);
    @(negedge clk);
    n_vec++;
    if (!ok || a_h !== 10'd0 || a_v !== 10'd1) begin
      n_err++;
      $display("FAIL line_wrap_a: got ok=%b h=%0d v=%0d want ok=1 h=0 v=1", ok, a_h, a_v);
    end
    wait_pos(1, 799, 10, 1'b1, 10000, ok);
    @(negedge clk);
    n_vec++;
    if (!ok || b_h !== 10'd0 || b_v !== 10'd11 || b_hs !== 1'b0) begin
      n_err++;
      $display("FAIL line_wrap_b: got ok=%b h=%0d v=%0d hs=%b want ok=1 h=0 v=11 hs=0",
               ok, b_h, b_v, b_hs);
    end
  endtask

  task automatic test_window();
    bit ok;
    int th[4] = '{143, 144, 783, 784};
    bit ex[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      wait_pos(1, th[i], 35, 1'b0, 30000, ok);
      n_vec++;
      if (!ok || b_br !== ex[i]) begin
        n_err++;
        $display("FAIL bright_at_%0d_35: got ok=%b br=%b want ok=1 br=%b", th[i], ok, b_br, ex[i]);
      end
    end
  endtask

  task automatic test_frame_wrap();
    bit found;
    int gap;
    rst_s = 1'b0;
    @(negedge clk);
    rst_s = 1'b1;
    for (int i = 1; i <= 257; i++) begin
      found = 1'b0;
      gap = 0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        exp_o = model_s(k_s);
        n_vec++;
        if (s_obs !== exp_o) begin
          n_err++;
          $display("FAIL model_s k=%0d: got %h want %h", k_s, s_obs, exp_o);
        end
        if (s_fs === 1'b1) begin
          found = 1'b1;
          gap = c;
          break;
        end
      end
      n_vec++;
      if (!found || gap != int'(SD * SHT * SVT) || s_fc !== 8'(i)) begin
        n_err++;
        $display("FAIL frame_%0d: got found=%b gap=%0d fc=%0d want found=1 gap=%0d fc=%0d",
                 i, found, gap, s_fc, SD * SHT * SVT, i % 256);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (s_fc == 8'd7 && s_h == 10'd5 && s_v == 10'd2) begin
        ok = 1'b1;
        break;
      end
    end
    rst_s = 1'b0;
    @(negedge clk);
    rst_s = 1'b1;
    n_vec++;
    if (!ok || s_h !== 10'd0 || s_v !== 10'd0 || s_fc !== 8'd0 || s_fs !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got ok=%b h=%0d v=%0d fc=%0d fs=%b want ok=1 h=0 v=0 fc=0 fs=0",
               ok, s_h, s_v, s_fc, s_fs);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      exp_o = model_s(k_s);
      n_vec++;
      if (s_obs !== exp_o) begin
        n_err++;
        $display("FAIL post_mid_reset k=%0d: got %h want %h", k_s, s_obs, exp_o);
      end
    end
  endtask

  task automatic test_random_resets();
    int run, hold;
    bit hit_a, hit_s;
    for (int it = 0; it < 40; it++) begin
      run = int'($urandom_range(0, 400));
      for (int c = 0; c < run; c++) begin
        @(negedge clk);
        exp_o = model_a(k_a);
        n_vec++;
        if (a_obs !== exp_o) begin
          n_err++;
          $display("FAIL rand_a k=%0d: got %h want %h", k_a, a_obs, exp_o);
        end
        exp_o = model_s(k_s);
        n_vec++;
        if (s_obs !== exp_o) begin
          n_err++;
          $display("FAIL rand_s k=%0d: got %h want %h", k_s, s_obs, exp_o);
        end
      end
      hit_a = ($urandom_range(0, 1) == 1);
      hit_s = ($urandom_range(0, 1) == 1);
      hold  = int'($urandom_range(1, 3));
      rst_a = !hit_a;
      rst_s = !hit_s;
      repeat (hold) @(negedge clk);
      rst_a = 1'b1;
      rst_s = 1'b1;
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_s = 1'b0;
    test_reset();
    test_sync();
    test_line_wrap();
    test_window();
    test_frame_wrap();
    test_mid_reset();
    test_random_resets();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
